// File: rtl/rf_pkg.sv
// Shared register-file write-back definitions.
// Contents: register-address and data widths, the load-size encoding,
// the load-return FIFO entry layout and a size-to-extension-control decoder.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LD_SIZE_W  = 3;

    typedef enum logic [LD_SIZE_W-1:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_size_e;

    // Size stays a raw code so unknown encodings can be carried and treated as LW.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
        logic [LD_SIZE_W-1:0]  size;
    } ld_entry_t;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lbu;
        logic lhu;
    } ld_ext_t;

    // One-hot extension control for sub-word loads; LW and unknown codes give all zero.
    function automatic ld_ext_t decode_size(logic [LD_SIZE_W-1:0] size);
        ld_ext_t ext;
        ext = '0;
        case (size)
            LD_LB:   ext.lb  = 1'b1;
            LD_LH:   ext.lh  = 1'b1;
            LD_LBU:  ext.lbu = 1'b1;
            LD_LHU:  ext.lhu = 1'b1;
            default: ext     = '0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// wb_fifo: synchronous FIFO buffering load returns ahead of the write port.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head), full_o, empty_o.
// Push while full and pop while empty are ignored. DEPTH must be a power of two.
module wb_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the ALU/jump
// result path and buffered load returns, with a pending-load scoreboard.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   alu_valid_i/alu_rd_i/alu_data_i -> alu_stall_o
//   ld_valid_i/ld_rd_i/ld_data_i/ld_size_i -> ld_ready_o
//   issue_i/issue_rd_i, rs1_i/rs2_i -> hazard_o
//   rf_we_o, rf_rw_o, rf_busw_o, rf_lb_o, rf_lh_o, rf_lbu_o, rf_lhu_o
// Build option: define RF_WB_SCOREBOARD_EN to build the pending-load scoreboard;
// without it hazard_o is 0 and the issue/rs inputs are ignored.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alu_valid_i,
    input  logic [4:0]       alu_rd_i,
    input  logic [WIDTH-1:0] alu_data_i,
    output logic             alu_stall_o,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [4:0]       ld_rd_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic [2:0]       ld_size_i,
    input  logic             issue_i,
    input  logic [4:0]       issue_rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    output logic             hazard_o,
    output logic             rf_we_o,
    output logic [4:0]       rf_rw_o,
    output logic [WIDTH-1:0] rf_busw_o,
    output logic             rf_lb_o,
    output logic             rf_lh_o,
    output logic             rf_lbu_o,
    output logic             rf_lhu_o
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    ld_entry_t         push_entry;
    ld_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              load_gnt;
    logic              alu_gnt;
    logic              wait_sat;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_d;
    ld_ext_t           ext;

    // Load-return buffer; acceptance depends only on registered occupancy.
    assign ld_ready_o = ~fifo_full;
    assign push_entry = '{rd: ld_rd_i, data: DATA_W'(ld_data_i), size: ld_size_i};

    wb_fifo #(
        .W     ($bits(ld_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ld_valid_i & ld_ready_o),
        .wdata_i (push_entry),
        .pop_i   (load_gnt),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Arbitration: loads take idle cycles, or force through once the head has waited MAX_WAIT.
    assign wait_sat = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign load_gnt = ~fifo_empty & (~alu_valid_i | wait_sat);
    assign alu_gnt  = alu_valid_i & ~load_gnt;

    // Write-port mux and extension decode.
    always_comb begin
        rf_we_o     = 1'b0;
        rf_rw_o     = '0;
        rf_busw_o   = '0;
        ext         = '0;
        alu_stall_o = alu_valid_i & load_gnt;
        if (load_gnt) begin
            rf_rw_o   = head.rd;
            rf_busw_o = WIDTH'(head.data);
            ext       = decode_size(head.size);
            rf_we_o   = (head.rd != '0);
        end else if (alu_gnt) begin
            rf_rw_o   = alu_rd_i;
            rf_busw_o = alu_data_i;
            rf_we_o   = (alu_rd_i != '0);
        end
    end

    assign rf_lb_o  = ext.lb;
    assign rf_lh_o  = ext.lh;
    assign rf_lbu_o = ext.lbu;
    assign rf_lhu_o = ext.lhu;

    // Counts cycles the current head has lost to the ALU.
    always_comb begin
        wait_cnt_d = wait_cnt;
        if (fifo_empty || load_gnt) begin
            wait_cnt_d = '0;
        end else if (alu_gnt && !wait_sat) begin
            wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) wait_cnt <= '0;
        else       wait_cnt <= wait_cnt_d;
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Clear on the load write, then set on issue so a same-rd issue wins.
    always_comb begin
        pend_d = pend_q;
        if (load_gnt && (head.rd != '0)) pend_d[head.rd] = 1'b0;
        if (issue_i && (issue_rd_i != '0)) pend_d[issue_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign hazard_o = pend_q[rs1_i] | pend_q[rs2_i];
`else
    logic sb_unused;
    assign sb_unused = ^{issue_i, issue_rd_i, rs1_i, rs2_i};
    assign hazard_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 3;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             alu_valid_i;
    logic [4:0]       alu_rd_i;
    logic [WIDTH-1:0] alu_data_i;
    logic             alu_stall_o;
    logic             ld_valid_i;
    logic             ld_ready_o;
    logic [4:0]       ld_rd_i;
    logic [WIDTH-1:0] ld_data_i;
    logic [2:0]       ld_size_i;
    logic             issue_i;
    logic [4:0]       issue_rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic             hazard_o;
    logic             rf_we_o;
    logic [4:0]       rf_rw_o;
    logic [WIDTH-1:0] rf_busw_o;
    logic             rf_lb_o;
    logic             rf_lh_o;
    logic             rf_lbu_o;
    logic             rf_lhu_o;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .alu_stall_o (alu_stall_o),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_rd_i     (ld_rd_i),
        .ld_data_i   (ld_data_i),
        .ld_size_i   (ld_size_i),
        .issue_i     (issue_i),
        .issue_rd_i  (issue_rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .hazard_o    (hazard_o),
        .rf_we_o     (rf_we_o),
        .rf_rw_o     (rf_rw_o),
        .rf_busw_o   (rf_busw_o),
        .rf_lb_o     (rf_lb_o),
        .rf_lh_o     (rf_lh_o),
        .rf_lbu_o    (rf_lbu_o),
        .rf_lhu_o    (rf_lhu_o)
    );

    // Reference model: queued load returns, cycles the head has lost, pending loads.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  size;
    } ent_t;

    ent_t        q[$];
    int unsigned age;
    bit [31:0]   pend;
    int          checks;
    int          failures;
    int          stall_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_ext(input logic [2:0] size);
        case (size)
            3'b000:  return 4'b1000;
            3'b001:  return 4'b0100;
            3'b100:  return 4'b0010;
            3'b101:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic idle();
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        alu_data_i  = '0;
        ld_valid_i  = 1'b0;
        ld_rd_i     = '0;
        ld_data_i   = '0;
        ld_size_i   = '0;
        issue_i     = 1'b0;
        issue_rd_i  = '0;
        rs1_i       = '0;
        rs2_i       = '0;
    endtask

    // One cycle: check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit   lg;
        bit   ag;
        int   n;
        ent_t h;
        #1;
        n  = q.size();
        lg = (n != 0) && (!alu_valid_i || age == MAX_WAIT);
        ag = alu_valid_i && !lg;
        chk("ld_ready", ld_ready_o, n < DEPTH);
        chk("alu_stall", alu_stall_o, alu_valid_i && lg);
        if (alu_stall_o === 1'b1) stall_seen++;
        if (lg) begin
            h = q[0];
            chk("ld_we", rf_we_o, h.rd != 0);
            chk("ld_rw", rf_rw_o, h.rd);
            chk("ld_busw", rf_busw_o, h.data);
            chk("ld_ext", {rf_lb_o, rf_lh_o, rf_lbu_o, rf_lhu_o}, exp_ext(h.size));
        end else if (ag) begin
            chk("alu_we", rf_we_o, alu_rd_i != 0);
            chk("alu_rw", rf_rw_o, alu_rd_i);
            chk("alu_busw", rf_busw_o, alu_data_i);
            chk("alu_ext", {rf_lb_o, rf_lh_o, rf_lbu_o, rf_lhu_o}, 4'b0000);
        end else begin
            chk("idle_we", rf_we_o, 1'b0);
        end
`ifdef RF_WB_SCOREBOARD_EN
        chk("hazard", hazard_o, pend[rs1_i] | pend[rs2_i]);
`else
        chk("hazard", hazard_o, 1'b0);
`endif
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            age  = 0;
            pend = '0;
        end else begin
            if (lg) begin
                void'(q.pop_front());
                age = 0;
                if (h.rd != 0) pend[h.rd] = 1'b0;
            end else if (ag && n != 0 && age < MAX_WAIT) begin
                age++;
            end
            if (ld_valid_i && n < DEPTH) q.push_back('{ld_rd_i, ld_data_i, ld_size_i});
            if (issue_i && issue_rd_i != 0) pend[issue_rd_i] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        stall_seen = 0;
        age        = 0;
        pend       = '0;
        idle();

        // Reset
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step();
        chk("rst_ready", ld_ready_o, 1'b1);
        rst_i = 1'b0;

        // ALU only
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h1234;
        step();

        // Idle-port load with scoreboard on rd 7
        idle(); issue_i = 1'b1; issue_rd_i = 5'd7;
        step();
        idle(); rs1_i = 5'd7; ld_valid_i = 1'b1; ld_rd_i = 5'd7; ld_data_i = 32'h0000_00F0; ld_size_i = 3'b000;
        step();
        idle(); rs1_i = 5'd7;
        #1 chk("lb_head", rf_lb_o, 1'b1);
        step();
        idle(); rs1_i = 5'd7;
        step();

        // Fairness: one load against continuous ALU traffic
        idle(); ld_valid_i = 1'b1; ld_rd_i = 5'd9; ld_data_i = 32'hCAFE; ld_size_i = 3'b001;
        step();
        stall_seen = 0;
        for (int i = 0; i < MAX_WAIT + 3; i++) begin
            idle(); alu_valid_i = 1'b1; alu_rd_i = 5'(i + 1); alu_data_i = $urandom;
            step();
        end
        chk("fair_stalls", 64'(stall_seen), 64'd1);

        // Full FIFO with ALU busy
        for (int i = 0; i < DEPTH + 2; i++) begin
            idle(); alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = $urandom;
            ld_valid_i = 1'b1; ld_rd_i = 5'(10 + i); ld_data_i = $urandom; ld_size_i = 3'(i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            idle(); alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = $urandom;
            step();
        end

        // Scoreboard race on rd 3
        idle(); issue_i = 1'b1; issue_rd_i = 5'd3;
        step();
        idle(); ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'h33; ld_size_i = 3'b010;
        step();
        idle(); issue_i = 1'b1; issue_rd_i = 5'd3;
        step();
        idle(); rs1_i = 5'd3;
        step();

        // Load to x0
        idle(); ld_valid_i = 1'b1; ld_rd_i = 5'd0; ld_data_i = 32'hDEAD; ld_size_i = 3'b100;
        step();
        idle();
        #1 chk("x0_we", rf_we_o, 1'b0);
        step();

        // Reset with two entries queued
        for (int i = 0; i < 2; i++) begin
            idle(); alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = $urandom;
            ld_valid_i = 1'b1; ld_rd_i = 5'(20 + i); ld_data_i = $urandom; ld_size_i = 3'b101;
            issue_i = 1'b1; issue_rd_i = 5'(22 + i);
            step();
        end
        idle(); rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        idle(); rs1_i = 5'd22; rs2_i = 5'd23;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_i       = ($urandom_range(0, 199) == 0);
            alu_valid_i = ($urandom_range(0, 99) < 55);
            alu_rd_i    = 5'($urandom);
            alu_data_i  = $urandom;
            ld_valid_i  = ($urandom_range(0, 99) < 45);
            ld_rd_i     = 5'($urandom);
            ld_data_i   = $urandom;
            ld_size_i   = 3'($urandom_range(0, 7));
            issue_i     = ($urandom_range(0, 99) < 35);
            issue_rd_i  = 5'($urandom);
            rs1_i       = 5'($urandom);
            rs2_i       = 5'($urandom);
            step();
        end
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
